// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types and constants.
// Imported by instruction_fetch and its decode-side users.
package instruction_fetch_pkg;

    localparam int          INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    function automatic logic [31:0] word_align(logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush.
// Used for the request-PC queue and the fetch buffer.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count
                   + {{AW{1'b0}}, do_push}
                   - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset; readers qualify with empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, credit-limited IMEM requests, fetch buffer.
// Redirects flush buffered words and drop in-flight responses.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [31:0]        imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [31:0]        if_pc,
    output logic [INSTR_W-1:0] if_instruction
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state;
    fetch_state_t state_nx;

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW:0]   credit_sum;
    logic          credit_ok;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          if_fire;

    logic [31:0]   pcq_rdata;
    logic          pcq_full;
    logic          pcq_empty;
    logic [CW-1:0] pcq_count;

    if_id_t        buf_wdata;
    if_id_t        buf_rdata;
    logic          buf_full;
    logic          buf_empty;
    logic [CW-1:0] buf_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_BOOT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_BOOT: state_nx = ST_RUN;
            ST_RUN:  state_nx = ST_RUN;
            default: state_nx = ST_BOOT;
        endcase
    end

    assign credit_sum = {1'b0, outstanding} + {1'b0, buf_count};
    assign credit_ok  = credit_sum < (CW+1)'(FIFO_DEPTH);

    assign imem_req_valid = (state == ST_RUN) && credit_ok
                          && !redirect_valid;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response during a redirect is stale along with the others.
    assign rsp_drop = imem_rsp_valid && (drop != '0);
    assign rsp_keep = imem_rsp_valid && (drop == '0)
                    && !redirect_valid;

    assign if_valid = !buf_empty;
    assign if_fire  = if_valid && if_ready;
    assign if_pc    = buf_empty ? 32'h0 : buf_rdata.pc;
    assign if_instruction = buf_empty ? NOP_INSTR
                                      : buf_rdata.instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding
                         + {{(CW-1){1'b0}}, req_fire}
                         - {{(CW-1){1'b0}}, imem_rsp_valid};
            if (redirect_valid) begin
                pc   <= word_align(redirect_pc);
                drop <= outstanding
                      - {{(CW-1){1'b0}}, imem_rsp_valid};
            end else begin
                if (req_fire) pc   <= pc + 32'd4;
                if (rsp_drop) drop <= drop - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_pcq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_fire),
        .pop   (rsp_keep),
        .flush (redirect_valid),
        .wdata (pc),
        .rdata (pcq_rdata),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count)
    );

    assign buf_wdata = '{pc: pcq_rdata, instr: imem_rsp_data};

    fetch_fifo #(
        .WIDTH ($bits(if_id_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_keep),
        .pop   (if_fire),
        .flush (redirect_valid),
        .wdata (buf_wdata),
        .rdata (buf_rdata),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    a_buf_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(rsp_keep && buf_full));

    a_pcq_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(req_fire && pcq_full));

    a_pcq_has_tag: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(rsp_keep && pcq_empty));

    a_inflight_balance: assert property (
        @(posedge clk) disable iff (!rst_n)
        ({1'b0, pcq_count} + {1'b0, drop}) == {1'b0, outstanding});

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch.
// A second instance checks PC wrap from a high reset PC.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = '0;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_instruction;

    int checks = 0;
    int errors = 0;

    instruction_fetch u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instruction (if_instruction)
    );

    instruction_fetch #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (1'b1),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .if_valid       (w_if_valid),
        .if_ready       (1'b1),
        .if_pc          (w_if_pc),
        .if_instruction (w_if_instruction)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          acc;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc = '0;
    int          n = 0;
    int          lat = 1;
    int          nreq = 0;
    int          npop = 0;
    logic        rand_ready = 1'b0;
    logic        want_first = 1'b0;
    logic [31:0] want_val = '0;

    always @(posedge clk) n <= n + 1;

    // IMEM model and scoreboard; decisions apply to the next edge.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            mem_q.delete();
            exp_q.delete();
            exp_pc = 32'h0;
            imem_rsp_valid = 1'b0;
        end else begin
            if (rand_ready) begin
                imem_req_ready = 1'($urandom_range(0, 1));
                if_ready = 1'($urandom_range(0, 3) != 0);
            end
            if (if_valid && if_ready) begin
                npop++;
                if (want_first) begin
                    check("first_pc", if_pc, want_val);
                    want_first = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    check("sb_extra", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e);
                    check("if_instr", if_instruction, ~e);
                end
            end
            if (redirect_valid) begin
                check("redir_noreq", {31'h0, imem_req_valid}, 0);
                exp_q.delete();
                exp_pc = redirect_pc & ~32'h3;
            end
            if (mem_q.size() > 0 && mem_q[0].acc + lat <= n + 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~mem_q[0].addr;
                void'(mem_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_pc);
                exp_q.push_back(exp_pc);
                mem_q.push_back('{imem_req_addr, n + 1});
                exp_pc += 32'd4;
                nreq++;
            end
        end
    end

    logic [31:0] w_exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC,
                               32'h0000_0000};
    logic        w_pend = 1'b0;
    logic [31:0] w_pend_addr = '0;
    int          w_j = 0;
    int          w_k = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            w_pend = 1'b0;
            w_rsp_valid = 1'b0;
        end else begin
            w_rsp_valid = w_pend;
            w_rsp_data  = ~w_pend_addr;
            if (w_if_valid && w_k < 3) begin
                check("wrap_if_pc", w_if_pc, w_exp[w_k]);
                check("wrap_if_instr", w_if_instruction,
                      ~w_exp[w_k]);
                w_k++;
            end
            if (w_req_valid && w_j < 3) begin
                check("wrap_addr", w_req_addr, w_exp[w_j]);
                w_j++;
            end
            w_pend      = w_req_valid;
            w_pend_addr = w_req_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1);
    end

    initial begin
        int nreq0;
        int npop0;
        #3;
        check("rst_req_valid", {31'h0, imem_req_valid}, 0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_if_valid", {31'h0, if_valid}, 0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instruction, 32'h0000_0013);

        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        check("boot_req", {31'h0, imem_req_valid}, 0);
        @(negedge clk); #1;
        check("run_req", {31'h0, imem_req_valid}, 1);
        npop0 = npop;
        repeat (30) @(posedge clk);
        #1 check("t1_progress", {31'h0, 1'(npop - npop0 >= 8)}, 1);

        @(posedge clk); #1 rst_n = 1'b0; if_ready = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        nreq0 = nreq;
        repeat (12) @(posedge clk);
        #1;
        check("t2_reqs", nreq - nreq0, 2);
        check("t2_stall", {31'h0, imem_req_valid}, 0);
        check("t2_ifv", {31'h0, if_valid}, 1);
        if_ready = 1'b1;
        npop0 = npop;
        repeat (10) @(posedge clk);
        #1 check("t2_drain", {31'h0, 1'(npop - npop0 >= 2)}, 1);

        lat = 3;
        for (int i = 0; i < 50 && mem_q.size() != 2; i++) begin
            @(posedge clk); #1;
        end
        check("t3_outst", mem_q.size(), 2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        want_first = 1'b1;
        want_val = 32'h0000_0100;
        @(posedge clk); #1 redirect_valid = 1'b0;
        for (int i = 0; i < 50 && want_first; i++) begin
            @(posedge clk); #1;
        end
        check("t3_seen", {31'h0, want_first}, 0);

        for (int i = 0; i < 50; i++) begin
            if (mem_q.size() > 0 && mem_q[0].acc + lat <= n + 1)
                break;
            @(posedge clk); #1;
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        want_first = 1'b1;
        want_val = 32'h0000_0100;
        @(posedge clk); #1 redirect_valid = 1'b0;
        check("t4_addr", imem_req_addr, 32'h0000_0100);
        for (int i = 0; i < 50 && want_first; i++) begin
            @(posedge clk); #1;
        end
        check("t4_seen", {31'h0, want_first}, 0);

        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(posedge clk); #1 redirect_pc = 32'h0000_0300;
        want_first = 1'b1;
        want_val = 32'h0000_0300;
        @(posedge clk); #1 redirect_valid = 1'b0;
        for (int i = 0; i < 50 && want_first; i++) begin
            @(posedge clk); #1;
        end
        check("b2b_seen", {31'h0, want_first}, 0);

        lat = 2;
        rand_ready = 1'b1;
        npop0 = npop;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            redirect_valid = 1'($urandom_range(0, 15) == 0);
            redirect_pc = $urandom & 32'h0000_FFFF;
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        rand_ready = 1'b0;
        if_ready = 1'b1;
        imem_req_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("rand_progress", {31'h0, 1'(npop - npop0 > 20)}, 1);

        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("arst_if_valid", {31'h0, if_valid}, 0);
        check("arst_if_instr", if_instruction, 32'h0000_0013);
        check("arst_if_pc", if_pc, 32'h0);
        check("arst_req_valid", {31'h0, imem_req_valid}, 0);
        check("arst_req_addr", imem_req_addr, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
